// File: rtl/exp_golomb_encoding.sv
// Exp-Golomb encoder for ue(v)/se(v)/te(v) syntax elements. Codewords are
// packed MSB-first into a bit buffer and emitted as 16-bit words.
module exp_golomb_encoding #(
  parameter int BUF_W = 40,
  parameter int CNT_W = 24
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_sel,
  input  logic [10:0]      in_value,
  input  logic [3:0]       te_range,
  input  logic             flush,
  output logic             flush_done,
  output logic [15:0]      out_word,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             code_err,
  output logic [CNT_W-1:0] bit_count
);

  localparam int CW = $clog2(BUF_W + 1);
  localparam logic [CW-1:0] LP_BUF  = CW'(BUF_W);
  localparam logic [CW-1:0] LP_WORD = CW'(16);

  typedef enum logic {ST_RUN = 1'b0, ST_FLUSH = 1'b1} state_t;

  state_t           r_state;
  logic [BUF_W-1:0] r_buf;
  logic [CW-1:0]    r_cnt;
  logic             r_out_valid;
  logic [15:0]      r_out_word;
  logic             r_code_err;
  logic             r_flush_done;
  logic [CNT_W-1:0] r_bit_count;

  logic [11:0]      w_code_num;
  logic [11:0]      w_x;
  logic [3:0]       w_m;
  logic [4:0]       w_len;
  logic [20:0]      w_code;
  logic             w_legal;
  logic             w_acc;
  logic             w_xfer;
  logic [BUF_W-1:0] w_buf_nxt;
  logic [CW-1:0]    w_cnt_nxt;
  logic [CW-1:0]    w_add;
  state_t           w_state_nxt;
  logic             w_flush_done;

  assign in_ready   = (r_state == ST_RUN) && (r_cnt <= LP_WORD) && !flush;
  assign out_valid  = r_out_valid;
  assign out_word   = r_out_word;
  assign code_err   = r_code_err;
  assign flush_done = r_flush_done;
  assign bit_count  = r_bit_count;
  assign w_acc      = in_valid && in_ready;
  assign w_xfer     = r_out_valid && out_ready;

  // codeword = (codeNum+1) in 2M+1 bits; its M leading zeros come for free
  always_comb begin
    w_code_num = 12'd0;
    w_legal    = 1'b0;
    w_m        = 4'd0;
    w_len      = 5'd0;
    w_code     = 21'd0;
    case (in_sel)
      2'b01, 2'b11: begin
        w_legal    = (in_value != 11'h7FF);
        w_code_num = {1'b0, in_value};
      end
      2'b10: begin
        w_legal = (in_value != 11'h400);
        if (!in_value[10] && (in_value != 11'd0)) begin
          w_code_num = {in_value, 1'b0} - 12'd1;
        end else begin
          w_code_num = 12'd0 - {in_value, 1'b0};
        end
      end
      default: begin
        w_legal    = 1'b0;
        w_code_num = 12'd0;
      end
    endcase
    w_x = w_code_num + 12'd1;
    for (int i = 0; i < 12; i++) begin
      if (w_x[i]) begin
        w_m = 4'(i);
      end
    end
    if ((in_sel == 2'b11) && (te_range <= 4'd1)) begin
      w_len  = 5'd1;
      w_code = {20'd0, ~in_value[0]};
    end else begin
      w_len  = {w_m, 1'b1};
      w_code = {9'd0, w_x};
    end
  end

  // Drain before append so a same-cycle accept lands right after the remaining bits
  always_comb begin
    w_buf_nxt    = r_buf;
    w_cnt_nxt    = r_cnt;
    w_add        = {CW{1'b0}};
    w_state_nxt  = r_state;
    w_flush_done = 1'b0;
    if (w_xfer) begin
      w_buf_nxt = r_buf << 16;
      w_cnt_nxt = r_cnt - LP_WORD;
    end else begin
      w_buf_nxt = r_buf;
      w_cnt_nxt = r_cnt;
    end
    if (w_acc && w_legal) begin
      w_buf_nxt = w_buf_nxt | (BUF_W'(w_code) << (LP_BUF - w_cnt_nxt - CW'(w_len)));
      w_cnt_nxt = w_cnt_nxt + CW'(w_len);
      w_add     = CW'(w_len);
    end else begin
      w_add = {CW{1'b0}};
    end
    case (r_state)
      ST_RUN: begin
        if (flush) begin
          w_state_nxt = ST_FLUSH;
        end else begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_FLUSH: begin
        if (r_cnt == {CW{1'b0}}) begin
          w_state_nxt  = ST_RUN;
          w_flush_done = 1'b1;
        end else if (r_cnt < LP_WORD) begin
          // buffer bits below count are always zero, so padding is a count bump
          w_cnt_nxt = LP_WORD;
          w_add     = LP_WORD - r_cnt;
        end else begin
          w_state_nxt = ST_FLUSH;
        end
      end
      default: begin
        w_state_nxt = ST_RUN;
      end
    endcase
  end

  // State, buffer and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_RUN;
      r_buf        <= {BUF_W{1'b0}};
      r_cnt        <= {CW{1'b0}};
      r_out_valid  <= 1'b0;
      r_out_word   <= 16'h0000;
      r_code_err   <= 1'b0;
      r_flush_done <= 1'b0;
      r_bit_count  <= {CNT_W{1'b0}};
    end else begin
      r_state      <= w_state_nxt;
      r_buf        <= w_buf_nxt;
      r_cnt        <= w_cnt_nxt;
      r_out_valid  <= (w_cnt_nxt >= LP_WORD);
      r_out_word   <= w_buf_nxt[BUF_W-1 -: 16];
      r_code_err   <= w_acc && !w_legal;
      r_flush_done <= w_flush_done;
      r_bit_count  <= r_bit_count + CNT_W'(w_add);
    end
  end

endmodule

// File: tb/tb_exp_golomb_encoding.sv
// Self-checking bench for exp_golomb_encoding: directed scenarios plus a
// randomized run against a bit-queue reference model.
module tb_exp_golomb_encoding;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_sel;
  logic [10:0] in_value;
  logic [3:0]  te_range;
  logic        flush;
  logic        flush_done;
  logic [15:0] out_word;
  logic        out_valid;
  logic        out_ready;
  logic        code_err;
  logic [23:0] bit_count;

  exp_golomb_encoding #(.BUF_W(40), .CNT_W(24)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_sel(in_sel), .in_value(in_value), .te_range(te_range), .flush(flush),
    .flush_done(flush_done), .out_word(out_word), .out_valid(out_valid),
    .out_ready(out_ready), .code_err(code_err), .bit_count(bit_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  logic s_acc, s_xfer, s_inr, s_ov, s_err, s_fd;
  logic [15:0] s_word;
  logic [23:0] s_bc;
  bit bq[$];
  logic [15:0] exp_q[$];
  logic [15:0] obs_q[$];
  int m_total, m_err, o_err, o_fd;

  task automatic push_bit(input bit b);
    logic [15:0] w;
    bq.push_back(b);
    m_total++;
    if (bq.size() == 16) begin
      w = 16'h0000;
      for (int i = 0; i < 16; i++) w = {w[14:0], bq.pop_front()};
      exp_q.push_back(w);
    end
  endtask

  // Reference encoder: arithmetic on the mapping rules, bits pushed one at a time
  task automatic model_push(input logic [1:0] sel, input logic [10:0] val, input logic [3:0] rng);
    int v, cn, x, m;
    bit ok;
    ok = 1'b0;
    cn = 0;
    if (sel == 2'b01 || sel == 2'b11) begin
      v = val;
      ok = (v <= 2046);
      cn = v;
    end else if (sel == 2'b10) begin
      v = $signed(val);
      ok = (v >= -1023 && v <= 1023);
      cn = (v > 0) ? 2 * v - 1 : -2 * v;
    end
    if (!ok) begin
      m_err++;
    end else if (sel == 2'b11 && rng <= 4'd1) begin
      push_bit(~val[0]);
    end else begin
      x = cn + 1;
      m = 0;
      while ((2 ** (m + 1)) <= x) m++;
      for (int i = 0; i < m; i++) push_bit(1'b0);
      for (int i = m; i >= 0; i--) push_bit(x[i]);
    end
  endtask

  task automatic model_pad();
    while (bq.size() != 0) push_bit(1'b0);
  endtask

  task automatic step();
    @(negedge clk);
    s_acc = in_valid && in_ready;
    s_xfer = out_valid && out_ready;
    s_inr = in_ready;
    s_ov = out_valid;
    s_word = out_word;
    s_err = code_err;
    s_fd = flush_done;
    s_bc = bit_count;
    if (s_xfer) obs_q.push_back(s_word);
    if (s_err) o_err++;
    if (s_fd) o_fd++;
    if (s_acc) model_push(in_sel, in_value, te_range);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    in_valid = 1'b0;
    flush = 1'b0;
    step();
    step();
    reset = 1'b0;
    bq.delete(); exp_q.delete(); obs_q.delete();
    m_total = 0; m_err = 0; o_err = 0; o_fd = 0;
  endtask

  task automatic send(input logic [1:0] sel, input logic [10:0] val, input logic [3:0] rng);
    int g;
    g = 0;
    in_valid = 1'b1; in_sel = sel; in_value = val; te_range = rng;
    do begin step(); g++; end while (!s_acc && g < 200);
    in_valid = 1'b0;
    if (!s_acc) begin
      n_err++;
      $display("FAIL accept_timeout sel=%b value=%h not accepted within 200 cycles", sel, val);
    end
  endtask

  task automatic do_flush(output bit ok, output int words_at_fd);
    int g;
    g = 0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    flush = 1'b1;
    step();
    model_pad();
    flush = 1'b0;
    do begin step(); g++; end while (!s_fd && g < 300);
    ok = s_fd;
    words_at_fd = obs_q.size();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic test_reset();
    do_reset();
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
    n_vec++; if (out_word !== 16'h0000) begin n_err++; $display("FAIL rst_out_word got %h want 0000", out_word); end
    n_vec++; if (code_err !== 1'b0) begin n_err++; $display("FAIL rst_code_err got %b want 0", code_err); end
    n_vec++; if (flush_done !== 1'b0) begin n_err++; $display("FAIL rst_flush_done got %b want 0", flush_done); end
    n_vec++; if (bit_count !== 24'd0) begin n_err++; $display("FAIL rst_bit_count got %0d want 0", bit_count); end
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_ue_zero();
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) send(2'b01, 11'd0, 4'd0);
    idle(4);
    n_vec++; if (obs_q.size() != 1 || obs_q[0] !== 16'hFFFF) begin n_err++; $display("FAIL ue0_word got n=%0d w=%h want n=1 w=ffff", obs_q.size(), obs_q[0]); end
    n_vec++; if (s_bc !== 24'd16) begin n_err++; $display("FAIL ue0_bit_count got %0d want 16", s_bc); end
  endtask

  task automatic test_mixed();
    bit ok; int wf;
    do_reset();
    out_ready = 1'b1;
    send(2'b01, 11'd3, 4'd0);
    send(2'b10, 11'h7FE, 4'd0);
    send(2'b10, 11'd1, 4'd0);
    do_flush(ok, wf);
    idle(2);
    n_vec++; if (!ok || wf != 1) begin n_err++; $display("FAIL mixed_flush_done got ok=%0d words=%0d want ok=1 words=1", ok, wf); end
    n_vec++; if (obs_q.size() != 1 || obs_q[0] !== 16'h2150) begin n_err++; $display("FAIL mixed_word got n=%0d w=%h want n=1 w=2150", obs_q.size(), obs_q[0]); end
    n_vec++; if (s_bc !== 24'd16) begin n_err++; $display("FAIL mixed_bit_count got %0d want 16", s_bc); end
  endtask

  task automatic test_te();
    bit ok; int wf;
    do_reset();
    out_ready = 1'b1;
    send(2'b11, 11'd0, 4'd1);
    send(2'b11, 11'd1, 4'd1);
    send(2'b11, 11'd2, 4'd3);
    do_flush(ok, wf);
    n_vec++; if (!ok || obs_q.size() != 1 || obs_q[0] !== 16'h9800) begin n_err++; $display("FAIL te_word got ok=%0d n=%0d w=%h want 1/1/9800", ok, obs_q.size(), obs_q[0]); end
    n_vec++; if (exp_q.size() != 1 || obs_q[0] !== exp_q[0]) begin n_err++; $display("FAIL te_model got %h want %h", obs_q[0], exp_q[0]); end
  endtask

  task automatic test_range();
    bit ok; int wf;
    do_reset();
    out_ready = 1'b1;
    send(2'b01, 11'd2046, 4'd0);
    do_flush(ok, wf);
    idle(2);
    n_vec++; if (!ok || obs_q.size() != 2 || obs_q[0] !== 16'h003F || obs_q[1] !== 16'hF800) begin n_err++; $display("FAIL range_words got n=%0d %h %h want 003f f800", obs_q.size(), obs_q[0], obs_q[1]); end
    n_vec++; if (s_bc !== 24'd32) begin n_err++; $display("FAIL range_bit_count got %0d want 32", s_bc); end
    send(2'b01, 11'h7FF, 4'd0);
    step();
    n_vec++; if (s_err !== 1'b1) begin n_err++; $display("FAIL err_ue2047 got %b want 1", s_err); end
    send(2'b10, 11'h400, 4'd0);
    step();
    n_vec++; if (s_err !== 1'b1) begin n_err++; $display("FAIL err_se_m1024 got %b want 1", s_err); end
    idle(3);
    n_vec++; if (o_err != 2 || s_err !== 1'b0) begin n_err++; $display("FAIL err_pulses got %0d want 2", o_err); end
    n_vec++; if (s_bc !== 24'd32 || obs_q.size() != 2) begin n_err++; $display("FAIL err_no_bits got bc=%0d n=%0d want 32/2", s_bc, obs_q.size()); end
  endtask

  task automatic test_backpressure();
    bit ok; int wf, g;
    do_reset();
    out_ready = 1'b0;
    send(2'b01, 11'd2046, 4'd0);
    in_valid = 1'b1; in_sel = 2'b01; in_value = 11'd2046;
    for (int i = 0; i < 4; i++) begin
      step();
      n_vec++; if (s_inr !== 1'b0 || s_ov !== 1'b1 || s_word !== 16'h003F) begin n_err++; $display("FAIL bp_hold got rdy=%b ov=%b w=%h want 0/1/003f", s_inr, s_ov, s_word); end
    end
    out_ready = 1'b1;
    g = 0;
    do begin step(); g++; end while (!s_acc && g < 50);
    in_valid = 1'b0;
    n_vec++; if (!s_acc) begin n_err++; $display("FAIL bp_second_accept got 0 want 1"); end
    do_flush(ok, wf);
    n_vec++; if (!ok || obs_q.size() != 3 || exp_q.size() != 3) begin n_err++; $display("FAIL bp_count got ok=%0d n=%0d want 3", ok, obs_q.size()); end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      n_vec++; if (obs_q[i] !== exp_q[i]) begin n_err++; $display("FAIL bp_word[%0d] got %h want %h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_back_to_back();
    bit ok; int wf;
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 16; i++) send(2'b01, 11'd0, 4'd0);
    out_ready = 1'b1;
    in_valid = 1'b1; in_sel = 2'b01; in_value = 11'd3;
    step();
    in_valid = 1'b0;
    n_vec++; if (!(s_acc && s_xfer)) begin n_err++; $display("FAIL b2b_same_cycle got acc=%b xfer=%b want 1/1", s_acc, s_xfer); end
    do_flush(ok, wf);
    n_vec++; if (!ok || obs_q.size() != 2 || obs_q[0] !== 16'hFFFF || obs_q[1] !== 16'h2000) begin n_err++; $display("FAIL b2b_words got n=%0d %h %h want ffff 2000", obs_q.size(), obs_q[0], obs_q[1]); end
  endtask

  task automatic test_reset_mid_flush();
    do_reset();
    out_ready = 1'b1;
    send(2'b01, 11'd3, 4'd0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    reset = 1'b1;
    #1;
    n_vec++; if (out_valid !== 1'b0 || out_word !== 16'h0000 || code_err !== 1'b0 || flush_done !== 1'b0 || bit_count !== 24'd0) begin
      n_err++; $display("FAIL midrst_outputs got ov=%b w=%h ce=%b fd=%b bc=%0d want all zero", out_valid, out_word, code_err, flush_done, bit_count);
    end
    step();
    step();
    reset = 1'b0;
    idle(3);
    n_vec++; if (obs_q.size() != 0 || o_fd != 0) begin n_err++; $display("FAIL midrst_quiet got words=%0d fd=%0d want 0/0", obs_q.size(), o_fd); end
    bq.delete(); exp_q.delete(); obs_q.delete(); m_total = 0;
    for (int i = 0; i < 16; i++) send(2'b01, 11'd0, 4'd0);
    idle(3);
    n_vec++; if (obs_q.size() != 1 || obs_q[0] !== 16'hFFFF || s_bc !== 24'd16) begin n_err++; $display("FAIL midrst_after got n=%0d w=%h bc=%0d want 1/ffff/16", obs_q.size(), obs_q[0], s_bc); end
  endtask

  task automatic test_random();
    bit ok; int wf, nfl, g, r;
    do_reset();
    nfl = 0;
    for (int k = 0; k < 300; k++) begin
      r = $urandom_range(0, 24);
      if (r == 0) begin
        do_flush(ok, wf);
        nfl++;
        n_vec++; if (!ok) begin n_err++; $display("FAIL rnd_flush_timeout k=%0d", k); end
      end
      in_sel = (r == 1) ? 2'b00 : 2'($urandom_range(1, 3));
      te_range = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) in_value = 11'($urandom_range(0, 2047));
      else if (in_sel == 2'b10 && $urandom_range(0, 1) == 1) in_value = 11'(2048 - $urandom_range(1, 20));
      else in_value = 11'($urandom_range(0, 20));
      in_valid = 1'b1;
      g = 0;
      do begin out_ready = 1'($urandom_range(0, 1)); step(); g++; end while (!s_acc && g < 200);
      in_valid = 1'b0;
      if (!s_acc) begin n_err++; $display("FAIL rnd_accept_timeout k=%0d", k); end
      if ($urandom_range(0, 2) == 0) begin out_ready = 1'($urandom_range(0, 1)); step(); end
    end
    do_flush(ok, wf);
    nfl++;
    idle(2);
    n_vec++; if (!ok || o_fd != nfl) begin n_err++; $display("FAIL rnd_flush_done got %0d want %0d", o_fd, nfl); end
    n_vec++; if (obs_q.size() != exp_q.size()) begin n_err++; $display("FAIL rnd_word_count got %0d want %0d", obs_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      n_vec++; if (obs_q[i] !== exp_q[i]) begin n_err++; $display("FAIL rnd_word[%0d] got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    n_vec++; if (s_bc !== 24'(m_total)) begin n_err++; $display("FAIL rnd_bit_count got %0d want %0d", s_bc, m_total); end
    n_vec++; if (o_err != m_err) begin n_err++; $display("FAIL rnd_code_err got %0d want %0d", o_err, m_err); end
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_sel = 2'b01; in_value = 11'd0;
    te_range = 4'd0; flush = 1'b0; out_ready = 1'b1;
    test_reset();
    test_ue_zero();
    test_mixed();
    test_te();
    test_range();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_flush();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
